// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         MD_CNT_W = 4;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy timer: loads MD_LATENCY on accept, counts down to idle.
import pipe_ctrl_pkg::*;

module md_busy_timer #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o
);

  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MD_LATENCY);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (start_i) begin
          cnt_d   = LAT;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) state_d = RUN;
      end
    endcase
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / redirect / mult-div hold+flush control for the 5-stage core.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             md_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic load_use;
  logic md_stall;
  logic hazard;
  logic stall;
  logic md_accept;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign md_stall  = md_busy && (id_md_start || id_reads_hilo);
  assign hazard    = load_use || md_stall;
  assign stall     = hazard && !ex_redirect;
  assign md_accept = id_md_start && !ex_redirect && !hazard;

  assign pc_hold     = stall;
  assign if_id_hold  = stall;
  assign if_id_flush = ex_redirect;
  assign id_ex_flush = ex_redirect || stall;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_accept),
    .busy_o  (md_busy)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: hold at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_hold && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_id_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// multi-cycle mult/div, redirect, reset and counter sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_md_start, id_reads_hilo;
  logic       ex_mem_read, ex_redirect;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_flush, md_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic        s_ph, s_ihh, s_iff, s_ief, s_busy;

  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .pc_hold(s_ph), .if_id_hold(s_ihh), .if_id_flush(s_iff),
    .id_ex_flush(s_ief), .md_busy(s_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
`endif

  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_busy(md_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ert;
    logic       urs, urt, mds, rhl, mr, red;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // exp packs {pc_hold, if_id_hold, if_id_flush, id_ex_flush, md_busy}
  task automatic chk_out(input string nm, input logic [4:0] exp);
    chk(nm, {27'd0, pc_hold, if_id_hold, if_id_flush, id_ex_flush, md_busy},
        {27'd0, exp});
    tests++;
    if (pc_hold !== if_id_hold || (if_id_hold && if_id_flush)) begin
      fails++;
      $display("FAIL %s_invariant: hold %b/%b flush %b", nm,
               pc_hold, if_id_hold, if_id_flush);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_md_start = 0;
    id_reads_hilo = 0; ex_mem_read = 0; ex_redirect = 0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; ex_rt = v.ert;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_md_start = v.mds;
    id_reads_hilo = v.rhl; ex_mem_read = v.mr; ex_redirect = v.red;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{"zero",      0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000};
    vecs[1]  = '{"lu_rs",     8, 0, 8, 1, 0, 0, 0, 1, 0, 5'b11010};
    vecs[2]  = '{"lu_r0",     0, 0, 0, 1, 0, 0, 0, 1, 0, 5'b00000};
    vecs[3]  = '{"lu_rt",     0, 5, 5, 0, 1, 0, 0, 1, 0, 5'b11010};
    vecs[4]  = '{"rt_unused", 0, 5, 5, 0, 0, 0, 0, 1, 0, 5'b00000};
    vecs[5]  = '{"no_load",   8, 0, 8, 1, 0, 0, 0, 0, 0, 5'b00000};
    vecs[6]  = '{"lu_redir",  8, 0, 8, 1, 0, 0, 0, 1, 1, 5'b00110};
    vecs[7]  = '{"redir",     0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00110};
    vecs[8]  = '{"md_redir",  0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b00110};
    vecs[9]  = '{"md_lu",     3, 0, 3, 1, 0, 1, 0, 1, 0, 5'b11010};
    vecs[10] = '{"hilo_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000};
    vecs[11] = '{"after",     9, 0, 7, 1, 0, 0, 0, 1, 0, 5'b00000};

    idle();
    rst = 1'b1;
    #2 chk_out("reset", 5'b00000);
    step();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step();
      apply(vecs[i]);
      #1 chk_out(vecs[i].name, vecs[i].exp);
    end

    // Mult accepted, mflo stalls t+1..t+4, passes at t+5
    step(); idle(); id_md_start = 1;
    #1 chk_out("md_accept", 5'b00000);
    step(); idle(); id_reads_hilo = 1;
    for (int k = 1; k <= 4; k++) begin
      #1 chk_out($sformatf("mflo_stall_%0d", k), 5'b11011);
      step();
    end
    #1 chk_out("mflo_pass", 5'b00000);

    // Redirect during busy does not cancel the timer
    step(); idle(); id_md_start = 1;
    step(); idle();
    #1 chk_out("rd_busy1", 5'b00001);
    step(); ex_redirect = 1;
    #1 chk_out("rd_busy2", 5'b00111);
    step(); idle();
    #1 chk_out("rd_busy3", 5'b00001);
    step();
    #1 chk_out("rd_busy4", 5'b00001);
    step();
    #1 chk_out("rd_done", 5'b00000);

    // md_start alongside a busy unit stalls rather than reloading
    step(); idle(); id_md_start = 1;
    step(); idle(); id_md_start = 1;
    #1 chk_out("md_md_stall", 5'b11011);

    // Async reset mid-busy releases a pending mflo immediately
    step(); idle();
    rst = 1; #1 rst = 0;
    step(); idle(); id_md_start = 1;
    step(); idle();
    step(); id_reads_hilo = 1;
    #1 chk_out("pre_rst_stall", 5'b11011);
    #1 rst = 1;
    #1 chk_out("rst_mid_busy", 5'b00000);
    #1 rst = 0;
    #1 chk_out("rst_released", 5'b00000);

`ifdef PIPE_CTRL_PERF_EN
    step(); idle();
    rst = 1; #1 rst = 0;
    step(); apply(vecs[1]);
    repeat (3) step();
    idle();
    #1 chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    chk("s_stall_cnt3", {30'd0, s_stall_cnt}, 32'd3);
    ex_redirect = 1;
    repeat (2) step();
    apply(vecs[1]);
    repeat (2) step();
    idle();
    #1 chk("stall_cnt5", {16'd0, stall_cnt}, 32'd5);
    chk("s_stall_sat", {30'd0, s_stall_cnt}, 32'd3);
    chk("flush_cnt2", {16'd0, flush_cnt}, 32'd2);
    chk("s_flush_cnt2", {30'd0, s_flush_cnt}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
